// File: rtl/processor_pkg.sv
// processor_pkg: loader state encoding, start-of-image byte and default address width
package processor_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam logic [7:0] MAGIC_BYTE = 8'hA5;
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input and program-memory write port of the loader
interface program_loader_if
  import processor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 16
);
  logic rx_valid;
  logic rx_ready;
  logic [7:0] rx_data;
  logic mem_wr_en;
  logic mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  modport master (
    input rx_valid, rx_data, mem_wr_ready,
    output rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
  modport slave (
    output rx_valid, rx_data, mem_wr_ready,
    input rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/loader_checksum.sv
// loader_checksum: 8-bit running sum with synchronous clear and add enable
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] data,
  output logic [7:0] sum
);
  always_ff @(posedge clk)
    if (rst || clr) sum <= '0;
    else if (add_en) sum <= sum + data;
endmodule

// File: rtl/program_loader.sv
// program_loader: writes a framed byte-stream image into program memory and holds the cpu in reset until it checks out
module program_loader
  import processor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 16,
  parameter int MAX_WORDS = 65535,
  parameter logic [7:0] MAGIC = MAGIC_BYTE
) (
  input  logic CLK,
  input  logic reset,
  program_loader_if.master bus,
  output logic cpu_reset,
  output logic load_done,
  output logic load_error
);
  state_t state, next;
  logic [7:0] len_hi, hi, sum;
  logic [15:0] len, count, len_w;
  logic rx_fire;
  assign bus.rx_ready = state != WRITE;
  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign len_w = {len_hi, bus.rx_data};
  always_ff @(posedge CLK)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state == WRITE) begin
      if (bus.mem_wr_ready) next = (count + 16'd1 == len) ? CHECK : DATA_HI;
    end else if (rx_fire) begin
      case (state)
        IDLE, DONE, ERROR: next = (bus.rx_data == MAGIC) ? LEN_HI : state;
        LEN_HI:  next = LEN_LO;
        LEN_LO:  next = (32'(len_w) > MAX_WORDS) ? ERROR : (len_w == 16'd0) ? CHECK : DATA_HI;
        DATA_HI: next = DATA_LO;
        DATA_LO: next = WRITE;
        CHECK:   next = (bus.rx_data == sum) ? DONE : ERROR;
        default: next = IDLE;
      endcase
    end
  end
  // Status flags follow the next state so they move exactly on transitions.
  always_ff @(posedge CLK)
    if (reset) begin
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_error <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
      len_hi <= '0;
      hi <= '0;
      len <= '0;
      count <= '0;
    end else begin
      cpu_reset <= next != DONE;
      load_done <= next == DONE;
      load_error <= next == ERROR;
      if (rx_fire && state == LEN_HI) len_hi <= bus.rx_data;
      if (rx_fire && state == LEN_LO) begin
        len <= len_w;
        count <= '0;
      end
      if (rx_fire && state == DATA_HI) hi <= bus.rx_data;
      if (rx_fire && state == DATA_LO) begin
        bus.mem_wr_en <= 1'b1;
        bus.mem_wr_addr <= ADDR_W'(count);
        bus.mem_wr_data <= DATA_W'({hi, bus.rx_data});
      end
      if (state == WRITE && bus.mem_wr_ready) begin
        bus.mem_wr_en <= 1'b0;
        count <= count + 16'd1;
      end
    end
  // Cleared on the length byte so a zero-length image checks against a fresh sum.
  loader_checksum u_chk (
    .clk(CLK),
    .rst(reset),
    .clr(rx_fire && state == LEN_LO),
    .add_en(rx_fire && (state == DATA_HI || state == DATA_LO)),
    .data(bus.rx_data),
    .sum(sum)
  );
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames against program_loader with a 4-word image limit
module tb_program_loader;
  logic CLK, reset, cpu_reset, load_done, load_error;
  int errors = 0;
  int checks = 0;
  int glitches = 0;
  int base;
  logic [31:0] wlog[$];
  logic [7:0] frame[$];
  program_loader_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  program_loader #(.ADDR_W(16), .DATA_W(16), .MAX_WORDS(4), .MAGIC(8'hA5)) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .load_error(load_error)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  always @(negedge CLK) begin
    if (!reset && bus.mem_wr_en && bus.mem_wr_ready) wlog.push_back({bus.mem_wr_addr, bus.mem_wr_data});
    if (bus.mem_wr_en && bus.rx_ready) glitches++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge CLK);
    while (!bus.rx_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge CLK);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
    bus.rx_valid = 1'b0;
  endtask
  task automatic flags(input string tag, input logic cr, input logic dn, input logic er);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
    check({tag, "_load_done"}, 32'(load_done), 32'(dn));
    check({tag, "_load_error"}, 32'(load_error), 32'(er));
  endtask
  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.mem_wr_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    flags("rst", 1'b1, 1'b0, 1'b0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_addr", 32'(bus.mem_wr_addr), 32'd0);
    check("rst_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    reset = 1'b0;
    // test 1: good two-word image, checksum 12+34+AB+CD = BE
    base = wlog.size();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_frame(frame);
    check("t1_nwr", 32'(wlog.size() - base), 32'd2);
    check("t1_w0", wlog[base], 32'h0000_1234);
    check("t1_w1", wlog[base+1], 32'h0001_ABCD);
    flags("t1", 1'b0, 1'b1, 1'b0);
    // test 2: bad checksum
    base = wlog.size();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
    send_frame(frame);
    check("t2_nwr", 32'(wlog.size() - base), 32'd2);
    check("t2_w1", wlog[base+1], 32'h0001_ABCD);
    flags("t2", 1'b1, 1'b0, 1'b1);
    // test 3: empty image, stray bytes, restart from DONE
    base = wlog.size();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(frame);
    flags("t3", 1'b0, 1'b1, 1'b0);
    frame = '{8'hFF, 8'h00};
    send_frame(frame);
    flags("t3_stray", 1'b0, 1'b1, 1'b0);
    frame = '{8'hA5};
    send_frame(frame);
    flags("t3_magic", 1'b1, 1'b0, 1'b0);
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(frame);
    check("t3_nwr", 32'(wlog.size() - base), 32'd0);
    flags("t3_again", 1'b0, 1'b1, 1'b0);
    // test 4: memory stalls the first write for 5 cycles
    base = wlog.size();
    bus.mem_wr_ready = 1'b0;
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    foreach (frame[i]) send(frame[i]);
    bus.rx_data = 8'hAB;
    for (int i = 0; i < 5; i++) begin
      check("t4_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("t4_wr_en", 32'(bus.mem_wr_en), 32'd1);
      check("t4_addr", 32'(bus.mem_wr_addr), 32'd0);
      check("t4_data", 32'(bus.mem_wr_data), 32'h1234);
      @(posedge CLK);
      #1;
    end
    bus.mem_wr_ready = 1'b1;
    frame = '{8'hAB, 8'hCD, 8'hBE};
    send_frame(frame);
    check("t4_nwr", 32'(wlog.size() - base), 32'd2);
    check("t4_w0", wlog[base], 32'h0000_1234);
    check("t4_w1", wlog[base+1], 32'h0001_ABCD);
    flags("t4", 1'b0, 1'b1, 1'b0);
    check("t4_wr_en_low", 32'(bus.mem_wr_en), 32'd0);
    // test 5: length above the limit, then a one-word image
    base = wlog.size();
    frame = '{8'hA5, 8'h00, 8'h05};
    send_frame(frame);
    flags("t5_err", 1'b1, 1'b0, 1'b1);
    check("t5_nwr", 32'(wlog.size() - base), 32'd0);
    frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h07};
    send_frame(frame);
    flags("t5_ok", 1'b0, 1'b1, 1'b0);
    check("t5_nwr1", 32'(wlog.size() - base), 32'd1);
    check("t5_w0", wlog[base], 32'h0000_0007);
    // length exactly at the limit is accepted
    frame = '{8'hA5, 8'h00, 8'h04};
    send_frame(frame);
    flags("t5_max", 1'b1, 1'b0, 1'b0);
    check("t5_max_rx_ready", 32'(bus.rx_ready), 32'd1);
    // test 6: reset in the middle of an image
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    send_frame(frame);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    flags("t6_rst", 1'b1, 1'b0, 1'b0);
    check("t6_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("t6_addr", 32'(bus.mem_wr_addr), 32'd0);
    check("t6_data", 32'(bus.mem_wr_data), 32'd0);
    check("t6_rx_ready", 32'(bus.rx_ready), 32'd1);
    base = wlog.size();
    frame = '{8'h56, 8'h78};
    send_frame(frame);
    repeat (4) @(posedge CLK);
    #1;
    check("t6_nwr", 32'(wlog.size() - base), 32'd0);
    check("t6_wr_en_idle", 32'(bus.mem_wr_en), 32'd0);
    flags("t6_idle", 1'b1, 1'b0, 1'b0);
    check("wr_en_outside_write", 32'(glitches), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
